// File: rtl/pulsador_pkg.sv
// Shared types and default timing for the push-button setting front end.
// Auto-repeat is built only when PULSADOR_AUTO_REPEAT_EN is defined.
package pulsador_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2,
        StLock   = 2'd3
    } estado_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_e;

    localparam int unsigned DebCyclesDef    = 500000;
    localparam int unsigned RepeatDelayDef  = 50000000;
    localparam int unsigned RepeatPeriodDef = 20000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/filtro_rebote.sv
// Two-flop synchronizer plus debounce filter for one raw button.
// The filtered level flips only after DEB_CYCLES consecutive differing samples.
module filtro_rebote
    import pulsador_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DebCyclesDef
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_filt
);

    localparam int unsigned CntW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CntLast) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_filt = filt_q;

endmodule

// File: rtl/pulsador_ajuste.sv
// Up/down button front end: debounced buttons drive one-cycle subir/bajar steps.
// Auto-repeat (REPEAT state and timer) exists only with PULSADOR_AUTO_REPEAT_EN.
module pulsador_ajuste
    import pulsador_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DebCyclesDef,
    parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
    parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef
) (
    input  logic clk,
    input  logic rst,
    input  logic w_r,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic subir,
    output logic bajar,
    output logic held
);

    localparam bit ParamsOk = (DEB_CYCLES >= 2) && (REPEAT_DELAY >= 2) && (REPEAT_PERIOD >= 2);

    if (!ParamsOk) begin : g_bad_params
        $error("pulsador_ajuste: timing parameters must all be >= 2");
    end

    logic up_f, down_f;

    filtro_rebote #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_filtro_up (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_up_raw),
        .btn_filt (up_f)
    );

    filtro_rebote #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_filtro_down (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_down_raw),
        .btn_filt (down_f)
    );

`ifdef PULSADOR_AUTO_REPEAT_EN
    localparam int unsigned TmrW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [TmrW-1:0] TmrDelay  = TmrW'(REPEAT_DELAY - 1);
    localparam logic [TmrW-1:0] TmrPeriod = TmrW'(REPEAT_PERIOD - 1);

    logic [TmrW-1:0] tmr_q, tmr_d;
`endif

    estado_e state_q, state_d;
    dir_e    dir_q, dir_d;
    logic    subir_q, subir_d;
    logic    bajar_q, bajar_d;
    logic    held_q, held_d;
    logic    latched_f, other_f;

    assign latched_f = (dir_q == DirDown) ? down_f : up_f;
    assign other_f   = (dir_q == DirDown) ? up_f : down_f;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        subir_d = 1'b0;
        bajar_d = 1'b0;
`ifdef PULSADOR_AUTO_REPEAT_EN
        tmr_d   = tmr_q;
`endif
        // Leaving edit mode with a button down parks in LOCK so it must be re-pressed.
        if (!w_r) begin
            state_d = (up_f || down_f) ? StLock : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (up_f ^ down_f) begin
                        dir_d   = up_f ? DirUp : DirDown;
                        subir_d = up_f;
                        bajar_d = down_f;
                        state_d = StDelay;
`ifdef PULSADOR_AUTO_REPEAT_EN
                        tmr_d   = TmrDelay;
`endif
                    end else if (up_f && down_f) begin
                        state_d = StLock;
                    end
                end
`ifdef PULSADOR_AUTO_REPEAT_EN
                StDelay, StRepeat: begin
`else
                StDelay: begin
`endif
                    if (!latched_f) begin
                        state_d = StIdle;
                    end else if (other_f) begin
                        state_d = StLock;
                    end else begin
`ifdef PULSADOR_AUTO_REPEAT_EN
                        if (tmr_q == '0) begin
                            subir_d = (dir_q == DirUp);
                            bajar_d = (dir_q == DirDown);
                            tmr_d   = TmrPeriod;
                            state_d = StRepeat;
                        end else begin
                            tmr_d = tmr_q - 1'b1;
                        end
`endif
                    end
                end
                StLock: begin
                    if (!up_f && !down_f) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
`ifdef PULSADOR_AUTO_REPEAT_EN
        held_d = (state_d == StDelay) || (state_d == StRepeat);
`else
        held_d = (state_d == StDelay);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DirUp;
            subir_q <= 1'b0;
            bajar_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef PULSADOR_AUTO_REPEAT_EN
            tmr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            subir_q <= subir_d;
            bajar_q <= bajar_d;
            held_q  <= held_d;
`ifdef PULSADOR_AUTO_REPEAT_EN
            tmr_q   <= tmr_d;
`endif
        end
    end

    assign subir = subir_q;
    assign bajar = bajar_q;
    assign held  = held_q;

endmodule

// File: tb/tb_pulsador_ajuste.sv
// Self-checking bench for pulsador_ajuste: directed scenarios plus random button traffic,
// compared cycle by cycle against a sample-window / elapsed-time reference model.
module tb_pulsador_ajuste;

    localparam int unsigned Deb = 4;
    localparam int unsigned Rd  = 20;
    localparam int unsigned Rp  = 8;
`ifdef PULSADOR_AUTO_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, w_r, up_raw, dn_raw;
    logic subir, bajar, held;

    always #5 clk = ~clk;

    pulsador_ajuste #(
        .DEB_CYCLES    (Deb),
        .REPEAT_DELAY  (Rd),
        .REPEAT_PERIOD (Rp)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .w_r          (w_r),
        .btn_up_raw   (up_raw),
        .btn_down_raw (dn_raw),
        .subir        (subir),
        .bajar        (bajar),
        .held         (held)
    );

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    // Reference model: mode 0 idle, 1 holding a single button, 2 locked.
    int m_mode;
    bit m_dir;
    int m_elapsed;
    bit m_fu, m_fd;
    bit m_subir, m_bajar;
    bit hist_u[$];
    bit hist_d[$];

    int sub_edges[$];
    int baj_edges[$];

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    // A level is accepted once the last Deb synchronized samples all disagree with it;
    // the synchronizer makes the sample seen at edge t the raw value sampled at t-2.
    function automatic bit all_differ(input bit q[$], input bit lvl);
        for (int i = 2; i <= int'(Deb) + 1; i++) begin
            if (q[q.size() - i] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit is_step(input int e);
        return (e == int'(Rd)) || (e > int'(Rd) && ((e - int'(Rd)) % int'(Rp)) == 0);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_dir = 1'b0; m_elapsed = 0;
        m_fu = 1'b0; m_fd = 1'b0; m_subir = 1'b0; m_bajar = 1'b0;
        hist_u.delete();
        hist_d.delete();
        for (int i = 0; i < int'(Deb) + 2; i++) begin
            hist_u.push_back(1'b0);
            hist_d.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        bit lat, oth, nfu, nfd;
        if (rst) begin
            model_reset();
            return;
        end
        m_subir = 1'b0;
        m_bajar = 1'b0;
        if (!w_r) begin
            m_mode = (m_fu || m_fd) ? 2 : 0;
        end else begin
            case (m_mode)
                0: begin
                    if (m_fu != m_fd) begin
                        m_dir = m_fd; m_subir = m_fu; m_bajar = m_fd;
                        m_elapsed = 0; m_mode = 1;
                    end else if (m_fu && m_fd) begin
                        m_mode = 2;
                    end
                end
                1: begin
                    lat = m_dir ? m_fd : m_fu;
                    oth = m_dir ? m_fu : m_fd;
                    if (!lat) m_mode = 0;
                    else if (oth) m_mode = 2;
                    else begin
                        m_elapsed++;
                        if (RepeatEn && is_step(m_elapsed)) begin
                            m_subir = !m_dir;
                            m_bajar = m_dir;
                        end
                    end
                end
                default: if (!m_fu && !m_fd) m_mode = 0;
            endcase
        end
        nfu = m_fu ^ all_differ(hist_u, m_fu);
        nfd = m_fd ^ all_differ(hist_d, m_fd);
        hist_u.push_back(up_raw);
        hist_d.push_back(dn_raw);
        if (hist_u.size() > 32) void'(hist_u.pop_front());
        if (hist_d.size() > 32) void'(hist_d.pop_front());
        m_fu = nfu;
        m_fd = nfd;
    endtask

    task automatic tick();
        @(posedge clk);
        edge_no++;
        model_edge();
        #1;
        check_eq("subir", subir, m_subir);
        check_eq("bajar", bajar, m_bajar);
        check_eq("held", held, (m_mode == 1));
        check_eq("excl", subir & bajar, 0);
        if (subir === 1'b1) sub_edges.push_back(edge_no);
        if (bajar === 1'b1) baj_edges.push_back(edge_no);
    endtask

    task automatic drive(input bit u, input bit d, input bit w, input int n);
        up_raw = u; dn_raw = d; w_r = w;
        repeat (n) tick();
    endtask

    function automatic int edge_at(input int q[$], input int i, input int base);
        return (i < q.size()) ? q[i] - base : -1;
    endfunction

    task automatic clear_pulses();
        sub_edges.delete();
        baj_edges.delete();
    endtask

    initial begin
        int base;
        int exp_dn[$];
        model_reset();
        rst = 1'b1; w_r = 1'b1; up_raw = 1'b0; dn_raw = 1'b0;
        repeat (3) tick();
        check_eq("rst_subir", subir, 0);
        check_eq("rst_held", held, 0);
        rst = 1'b0;
        drive(0, 0, 1, 5);

        // Clean up press held 12 cycles.
        clear_pulses();
        base = edge_no + 1;
        drive(1, 0, 1, 12);
        drive(0, 0, 1, 12);
        check_eq("s1_nsub", sub_edges.size(), 1);
        check_eq("s1_edge", edge_at(sub_edges, 0, base), 6);
        check_eq("s1_nbaj", baj_edges.size(), 0);

        // Bounce, then stable press.
        clear_pulses();
        drive(1, 0, 1, 1); drive(0, 0, 1, 1); drive(1, 0, 1, 1); drive(0, 0, 1, 1);
        base = edge_no + 1;
        drive(1, 0, 1, 14);
        drive(0, 0, 1, 12);
        check_eq("s2_nsub", sub_edges.size(), 1);
        check_eq("s2_edge", edge_at(sub_edges, 0, base), 6);

        // Down held 60 cycles.
        clear_pulses();
        base = edge_no + 1;
        drive(0, 1, 1, 60);
        drive(0, 0, 1, 14);
        if (RepeatEn) exp_dn = '{6, 26, 34, 42, 50, 58};
        else exp_dn = '{6};
        check_eq("s3_nbaj", baj_edges.size(), exp_dn.size());
        foreach (exp_dn[i]) check_eq("s3_edge", edge_at(baj_edges, i, base), exp_dn[i]);
        check_eq("s3_nsub", sub_edges.size(), 0);

        // Opposite button during DELAY locks until both are released.
        drive(1, 0, 1, 10);
        clear_pulses();
        drive(1, 1, 1, 30);
        drive(0, 0, 1, 12);
        check_eq("s4_lock_sub", sub_edges.size(), 0);
        check_eq("s4_lock_baj", baj_edges.size(), 0);
        drive(1, 0, 1, 10);
        drive(0, 0, 1, 12);
        check_eq("s4_after_sub", sub_edges.size(), 1);

        // Edit mode off while pressed, then on with button still held.
        clear_pulses();
        drive(1, 0, 0, 12);
        drive(1, 0, 1, 20);
        drive(0, 0, 1, 12);
        check_eq("s5_wr_sub", sub_edges.size(), 0);
        drive(1, 0, 1, 10);
        drive(0, 0, 1, 12);
        check_eq("s5_again_sub", sub_edges.size(), 1);

        // Reset in the middle of a hold.
        drive(0, 1, 1, 30);
        rst = 1'b1; dn_raw = 1'b0;
        tick();
        check_eq("s6_rst_baj", bajar, 0);
        check_eq("s6_rst_held", held, 0);
        rst = 1'b0;
        clear_pulses();
        drive(0, 0, 1, 20);
        check_eq("s6_quiet", baj_edges.size(), 0);
        drive(0, 1, 1, 10);
        drive(0, 0, 1, 12);
        check_eq("s6_again_baj", baj_edges.size(), 1);

        // Random traffic with bounces, edit-mode drops and occasional reset.
        for (int s = 0; s < 700; s++) begin
            bit u, d, w;
            int len, bl;
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 6) != 0);
            len = $urandom_range(1, 45);
            bl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            for (int i = 0; i < len; i++) begin
                rst = ($urandom_range(0, 399) == 0);
                w_r = w;
                up_raw = (i < bl) ? 1'($urandom_range(0, 1)) : u;
                dn_raw = (i < bl) ? 1'($urandom_range(0, 1)) : d;
                tick();
            end
            rst = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
